// File: rtl/retry_engine_mq.sv
// retry_engine_mq: multi-QoS retry engine guarding a shared command buffer.
// Define RETRY_AGING_EN to enable anti-starvation aging of retry table entries.
module retry_engine_mq #(
    parameter int SRC_NODE_W    = 4,
    parameter int CMD_ENTRY_NUM = 8,
    parameter int RTY_ENTRY_NUM = 8,
    parameter int PAYLD_BW      = 32,
    parameter int QoS_CLASS     = 4,
    parameter int AGE_TH        = 15,
    parameter int QOS_W         = (QoS_CLASS > 1) ? $clog2(QoS_CLASS) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  vld_req_in,
    output logic                  rdy_req_in,
    input  logic                  req_type,
    input  logic                  req_credit,
    input  logic [QOS_W-1:0]      qos_type,
    input  logic [SRC_NODE_W-1:0] src_id,
    input  logic [PAYLD_BW-1:0]   payload_in,
    output logic                  vld_rty_out,
    input  logic                  rdy_rty_out,
    output logic [SRC_NODE_W-1:0] rty_des_id,
    output logic                  vld_out_grant,
    input  logic                  rdy_out_grant,
    output logic [SRC_NODE_W-1:0] grant_des_id,
    output logic                  vld_resp_out,
    input  logic                  rdy_resp_out,
    output logic [PAYLD_BW-1:0]   payload_out,
    output logic                  err_credit
);

    localparam int CW = $clog2(CMD_ENTRY_NUM + 1);
    localparam int PW = $clog2(CMD_ENTRY_NUM);
    localparam int TW = (RTY_ENTRY_NUM > 1) ? $clog2(RTY_ENTRY_NUM) : 1;
    localparam logic [CW-1:0] DEPTH = CW'(CMD_ENTRY_NUM);
    localparam logic [PW-1:0] LAST  = PW'(CMD_ENTRY_NUM - 1);
`ifdef RETRY_AGING_EN
    localparam int AW = $clog2(AGE_TH + 1);
    localparam int KW = QOS_W + AW;
    localparam logic [QOS_W-1:0] QMAX = QOS_W'(QoS_CLASS - 1);
    localparam logic [AW-1:0]    ATH  = AW'(AGE_TH);
`else
    localparam int KW = QOS_W;
`endif

    generate
        if (CMD_ENTRY_NUM < 2 || RTY_ENTRY_NUM < 1 || AGE_TH < 1) begin : g_bad_cfg
            $error("retry_engine_mq: illegal parameter set");
        end
    endgenerate

    logic [PAYLD_BW-1:0]   mem [CMD_ENTRY_NUM];
    logic [PW-1:0]         wr_ptr, rd_ptr;
    logic [CW-1:0]         cnt, rsv, free;
    logic [RTY_ENTRY_NUM-1:0] tbl_vld;
    logic [SRC_NODE_W-1:0] tbl_src [RTY_ENTRY_NUM];
    logic [QOS_W-1:0]      tbl_qos [RTY_ENTRY_NUM];
    logic [KW-1:0]         key [RTY_ENTRY_NUM];

    logic          has_free, rty_ok, hs, push, log_rty, pop;
    logic          free_push, room, gnt_fire;
    logic [TW-1:0] slot, best_idx;
    logic          slot_hit, best_hit;
    logic [KW-1:0] best_key;

    assign free     = DEPTH - cnt - rsv;
    assign has_free = (free != '0);
    assign rty_ok   = !vld_rty_out || rdy_rty_out;

    always_comb begin
        rdy_req_in = 1'b0;
        if (req_credit)
            rdy_req_in = (rsv != '0);
        else if (has_free)
            rdy_req_in = 1'b1;
        else if (req_type)
            rdy_req_in = slot_hit && rty_ok;
    end

    assign hs        = vld_req_in && rdy_req_in;
    assign push      = hs && (req_credit || has_free);
    assign log_rty   = hs && !req_credit && !has_free;
    assign pop       = vld_resp_out && rdy_resp_out;
    // A credit re-send lands in its reserved slot and leaves free untouched
    assign free_push = push && !req_credit;
    assign room      = free_push ? (free > CW'(1)) : has_free;
    assign gnt_fire  = room && best_hit && (!vld_out_grant || rdy_out_grant);

    always_comb begin
        slot     = '0;
        slot_hit = 1'b0;
        for (int i = 0; i < RTY_ENTRY_NUM; i++) begin
            if (!tbl_vld[i] && !slot_hit) begin
                slot     = TW'(i);
                slot_hit = 1'b1;
            end
        end
    end

`ifdef RETRY_AGING_EN
    logic [AW-1:0] tbl_age [RTY_ENTRY_NUM];

    // Promoted entries rank at the top class and then by age
    always_comb begin
        for (int i = 0; i < RTY_ENTRY_NUM; i++) begin
            key[i] = {tbl_qos[i], {AW{1'b0}}};
            if (tbl_age[i] >= ATH)
                key[i] = {QMAX, tbl_age[i]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < RTY_ENTRY_NUM; i++)
                tbl_age[i] <= '0;
        end else begin
            for (int i = 0; i < RTY_ENTRY_NUM; i++) begin
                if (log_rty && slot == TW'(i))
                    tbl_age[i] <= '0;
                else if (tbl_vld[i] && !(gnt_fire && best_idx == TW'(i))
                         && tbl_age[i] != {AW{1'b1}})
                    tbl_age[i] <= tbl_age[i] + AW'(1);
            end
        end
    end
`else
    always_comb begin
        for (int i = 0; i < RTY_ENTRY_NUM; i++)
            key[i] = tbl_qos[i];
    end
`endif

    always_comb begin
        best_idx = '0;
        best_key = '0;
        best_hit = 1'b0;
        for (int i = 0; i < RTY_ENTRY_NUM; i++) begin
            if (tbl_vld[i] && (!best_hit || key[i] > best_key)) begin
                best_idx = TW'(i);
                best_key = key[i];
                best_hit = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= payload_in;
    end

    assign vld_resp_out = (cnt != '0);
    assign payload_out  = vld_resp_out ? mem[rd_ptr] : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            rsv    <= '0;
        end else begin
            if (push)
                wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + PW'(1);
            if (pop)
                rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + PW'(1);
            if (push && !pop)
                cnt <= cnt + CW'(1);
            else if (!push && pop)
                cnt <= cnt - CW'(1);
            if (gnt_fire && !(push && req_credit))
                rsv <= rsv + CW'(1);
            else if (!gnt_fire && push && req_credit)
                rsv <= rsv - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tbl_vld <= '0;
            for (int i = 0; i < RTY_ENTRY_NUM; i++) begin
                tbl_src[i] <= '0;
                tbl_qos[i] <= '0;
            end
        end else begin
            if (gnt_fire)
                tbl_vld[best_idx] <= 1'b0;
            if (log_rty) begin
                tbl_vld[slot] <= 1'b1;
                tbl_src[slot] <= src_id;
                tbl_qos[slot] <= qos_type;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_rty_out   <= 1'b0;
            rty_des_id    <= '0;
            vld_out_grant <= 1'b0;
            grant_des_id  <= '0;
            err_credit    <= 1'b0;
        end else begin
            if (log_rty) begin
                vld_rty_out <= 1'b1;
                rty_des_id  <= src_id;
            end else if (rdy_rty_out) begin
                vld_rty_out <= 1'b0;
            end
            if (gnt_fire) begin
                vld_out_grant <= 1'b1;
                grant_des_id  <= tbl_src[best_idx];
            end else if (rdy_out_grant) begin
                vld_out_grant <= 1'b0;
            end
            if (vld_req_in && req_credit && rsv == '0)
                err_credit <= 1'b1;
        end
    end

endmodule

// File: tb/tb_retry_engine_mq.sv
// tb_retry_engine_mq: randomized scoreboard bench for retry_engine_mq.
// Expected payloads, retry ids and grant ids come from a queue-based model.
module tb_retry_engine_mq;

    localparam int N   = 8;
    localparam int R   = 8;
    localparam int QC  = 4;
    localparam int ATH = 15;
    localparam int AMAX = (1 << $clog2(ATH + 1)) - 1;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        vld_req_in, rdy_req_in, req_type, req_credit;
    logic [1:0]  qos_type;
    logic [3:0]  src_id;
    logic [31:0] payload_in;
    logic        vld_rty_out, rdy_rty_out;
    logic [3:0]  rty_des_id;
    logic        vld_out_grant, rdy_out_grant;
    logic [3:0]  grant_des_id;
    logic        vld_resp_out, rdy_resp_out;
    logic [31:0] payload_out;
    logic        err_credit;

    retry_engine_mq #(
        .SRC_NODE_W(4), .CMD_ENTRY_NUM(N), .RTY_ENTRY_NUM(R),
        .PAYLD_BW(32), .QoS_CLASS(QC), .AGE_TH(ATH)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .vld_req_in(vld_req_in), .rdy_req_in(rdy_req_in),
        .req_type(req_type), .req_credit(req_credit),
        .qos_type(qos_type), .src_id(src_id), .payload_in(payload_in),
        .vld_rty_out(vld_rty_out), .rdy_rty_out(rdy_rty_out),
        .rty_des_id(rty_des_id),
        .vld_out_grant(vld_out_grant), .rdy_out_grant(rdy_out_grant),
        .grant_des_id(grant_des_id),
        .vld_resp_out(vld_resp_out), .rdy_resp_out(rdy_resp_out),
        .payload_out(payload_out), .err_credit(err_credit)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // reference model state
    int  m_cnt, m_rsv;
    bit  m_rty, m_gnt, m_err;
    bit  t_v[R];
    int  t_s[R], t_q[R], t_a[R];
    logic [31:0] exp_resp[$];
    int  exp_rty[$];
    int  exp_gnt[$];

    int  mf, mnv, mslot, mbest, mkey, mbkey;
    bit  mrdy, mpush, mlog, mpop, mgnt, mroom;

    function automatic int eff_key(int i);
`ifdef RETRY_AGING_EN
        if (t_a[i] >= ATH)
            return (QC - 1) * 64 + t_a[i];
        return t_q[i] * 64;
`else
        return t_q[i];
`endif
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            m_cnt = 0; m_rsv = 0;
            m_rty = 0; m_gnt = 0; m_err = 0;
            for (int i = 0; i < R; i++) begin
                t_v[i] = 0; t_s[i] = 0; t_q[i] = 0; t_a[i] = 0;
            end
            exp_resp.delete();
            exp_rty.delete();
            exp_gnt.delete();
        end else begin
            mf  = N - m_cnt - m_rsv;
            mnv = 0;
            mslot = -1;
            for (int i = 0; i < R; i++) begin
                if (t_v[i]) mnv++;
                else if (mslot < 0) mslot = i;
            end
            if (req_credit)      mrdy = (m_rsv > 0);
            else if (mf > 0)     mrdy = 1;
            else if (req_type)   mrdy = (mnv < R) && (!m_rty || rdy_rty_out);
            else                 mrdy = 0;

            chk("rdy_req_in", rdy_req_in, mrdy);
            chk("vld_resp_out", vld_resp_out, m_cnt > 0);
            chk("vld_rty_out", vld_rty_out, m_rty);
            chk("vld_out_grant", vld_out_grant, m_gnt);
            chk("err_credit", err_credit, m_err);

            mpush = vld_req_in && mrdy && (req_credit || mf > 0);
            mlog  = vld_req_in && mrdy && !req_credit && mf == 0;
            mpop  = (m_cnt > 0) && rdy_resp_out;
            mroom = (mf - ((mpush && !req_credit) ? 1 : 0)) > 0;
            mgnt  = mroom && mnv > 0 && (!m_gnt || rdy_out_grant);

            mbest = -1;
            mbkey = -1;
            if (mgnt) begin
                for (int i = 0; i < R; i++) begin
                    mkey = eff_key(i);
                    if (t_v[i] && mkey > mbkey) begin
                        mbest = i;
                        mbkey = mkey;
                    end
                end
            end

            if (vld_req_in && req_credit && m_rsv == 0) m_err = 1;
            if (mpush) exp_resp.push_back(payload_in);
            if (mpush && req_credit) m_rsv--;
            m_cnt += (mpush ? 1 : 0) - (mpop ? 1 : 0);

            if (mlog) m_rty = 1;
            else if (rdy_rty_out) m_rty = 0;

            for (int i = 0; i < R; i++)
                if (t_v[i] && i != mbest && t_a[i] < AMAX) t_a[i]++;

            if (mgnt) begin
                exp_gnt.push_back(t_s[mbest]);
                t_v[mbest] = 0;
                m_rsv++;
                m_gnt = 1;
            end else if (rdy_out_grant) begin
                m_gnt = 0;
            end

            if (mlog) begin
                exp_rty.push_back(int'(src_id));
                t_v[mslot] = 1;
                t_s[mslot] = int'(src_id);
                t_q[mslot] = int'(qos_type);
                t_a[mslot] = 0;
            end
        end
    end

    // monitors: compare DUT output handshakes with the scoreboard queues
    always @(negedge clk) begin
        if (rst_n && vld_resp_out && rdy_resp_out) begin
            if (exp_resp.size() == 0)
                chk("resp_unexpected", 1, 0);
            else
                chk("payload_out", payload_out, exp_resp.pop_front());
        end
        if (rst_n && vld_rty_out && rdy_rty_out) begin
            if (exp_rty.size() == 0)
                chk("rty_unexpected", 1, 0);
            else
                chk("rty_des_id", rty_des_id, exp_rty.pop_front());
        end
        if (rst_n && vld_out_grant && rdy_out_grant) begin
            if (exp_gnt.size() == 0)
                chk("grant_unexpected", 1, 0);
            else
                chk("grant_des_id", grant_des_id, exp_gnt.pop_front());
        end
    end

    task automatic idle_inputs();
        vld_req_in = 0; req_type = 0; req_credit = 0;
        qos_type = 0; src_id = 0; payload_in = 0;
        rdy_rty_out = 0; rdy_out_grant = 0; rdy_resp_out = 0;
    endtask

    task automatic check_cleared(input string tag);
        chk({tag, "_vld_rty"}, vld_rty_out, 0);
        chk({tag, "_vld_gnt"}, vld_out_grant, 0);
        chk({tag, "_vld_resp"}, vld_resp_out, 0);
        chk({tag, "_err"}, err_credit, 0);
        chk({tag, "_rty_id"}, rty_des_id, 0);
        chk({tag, "_gnt_id"}, grant_des_id, 0);
        chk({tag, "_payload"}, payload_out, 0);
    endtask

    task automatic run(input int cycles, input int p_req, input int p_type,
                       input int p_pop, input int p_cred, input bit allow_err);
        for (int c = 0; c < cycles; c++) begin
            @(posedge clk);
            #1;
            vld_req_in = ($urandom_range(99) < p_req);
            if (m_rsv > 0 && $urandom_range(99) < p_cred)
                req_credit = 1;
            else if (allow_err && $urandom_range(99) < 3)
                req_credit = 1;
            else
                req_credit = 0;
            req_type      = ($urandom_range(99) < p_type);
            qos_type      = 2'($urandom_range(3));
            src_id        = 4'($urandom_range(15));
            payload_in    = $urandom;
            rdy_resp_out  = ($urandom_range(99) < p_pop);
            rdy_rty_out   = ($urandom_range(99) < 70);
            rdy_out_grant = ($urandom_range(99) < 60);
        end
    endtask

    initial begin
        rst_n = 0;
        idle_inputs();
        repeat (3) @(posedge clk);
        #1;
        check_cleared("reset");
        rst_n = 1;

        run(200, 90, 80, 10, 40, 0);
        run(100, 90, 100, 0, 0, 0);
        run(200, 70, 60, 50, 40, 1);

        @(posedge clk);
        #3;
        rst_n = 0;
        #1;
        check_cleared("midreset");
        idle_inputs();
        @(posedge clk);
        #1;
        rst_n = 1;

        run(300, 80, 70, 30, 50, 1);
        run(150, 95, 90, 5, 20, 0);

        @(posedge clk);
        #1;
        idle_inputs();
        rdy_resp_out = 1;
        rdy_rty_out = 1;
        rdy_out_grant = 1;
        repeat (60) @(posedge clk);
        #1;
        chk("drain_resp", exp_resp.size(), 0);
        chk("drain_rty", exp_rty.size(), 0);
        chk("drain_gnt", exp_gnt.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/retry_engine_mq.md
Name: retry_engine_mq

Overview:
Multi-QoS retry engine in front of a shared command buffer. Incoming requests are either accepted into the buffer, bounced with a retry response, or back-pressured. Bounced sources are logged and later receive a credit grant, which reserves a buffer slot for their re-send. This is the parametrised successor of the single-class RetryEngine, adding reserved credits, configurable QoS classes and optional anti-starvation aging.

Parameters:
SRC_NODE_W, 4, source/destination node id width
CMD_ENTRY_NUM, 8, command buffer depth (>=2)
RTY_ENTRY_NUM, 8, retry table depth (>=1)
PAYLD_BW, 32, payload width
QoS_CLASS, 4, number of QoS classes; QOS_W = max(1,$clog2(QoS_CLASS)); higher value = higher priority
AGE_TH, 15, aging threshold in cycles (used only with RETRY_AGING_EN)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
vld_req_in  in  1  request valid
rdy_req_in  out  1  request ready
req_type  in  1  0: retry not allowed; 1: retry allowed
req_credit  in  1  1: re-send consuming a previously granted credit
qos_type  in  QOS_W  request QoS class
src_id  in  SRC_NODE_W  requester id
payload_in  in  PAYLD_BW  request payload
vld_rty_out  out  1  retry response valid
rdy_rty_out  in  1  retry response ready
rty_des_id  out  SRC_NODE_W  id of retried source
vld_out_grant  out  1  credit grant valid
rdy_out_grant  in  1  credit grant ready
grant_des_id  out  SRC_NODE_W  id of granted source
vld_resp_out  out  1  buffered command valid
rdy_resp_out  in  1  downstream ready
payload_out  out  PAYLD_BW  buffered payload (FIFO head)
err_credit  out  1  sticky: credit re-send arrived with no reserved credit

Behaviour:
- Reset: all valids, err_credit, cnt, rsv and retry table cleared; data outputs 0. Reset mid-operation discards outstanding grants and retries; sources re-request.
- State: FIFO count cnt, reserved credits rsv, both from registers; invariant cnt+rsv <= CMD_ENTRY_NUM. free = CMD_ENTRY_NUM-cnt-rsv, using registered values only (a pop does not free space for a same-cycle push).
- rdy_req_in is combinational from state and request qualifiers:
  - req_credit=1: ready iff rsv>0. If rsv=0 while valid, ready=0 and err_credit sets.
  - else free>0: ready=1.
  - else req_type=1: ready iff retry table not full and (!vld_rty_out or rdy_rty_out).
  - else: ready=0.
- On handshake:
  - credit path: push, rsv--.
  - free path: push.
  - retry path: no push; write {src_id,qos_type,age=0} into the lowest free table slot; load the retry register (vld_rty_out=1, rty_des_id=src_id) the next cycle. The retry response is held until rdy_rty_out.
- Grant selection: each cycle, if free>0 after this cycle's accepted push, the table is non-empty, and (!vld_out_grant or rdy_out_grant), pick the highest effective QoS entry. Ties go to the lowest index. The picked entry is freed, rsv++, and vld_out_grant/grant_des_id register next cycle, held until rdy_out_grant.
- Output: vld_resp_out = cnt>0, payload_out = head, pop on vld&&rdy. Push/pop in the same cycle leaves cnt unchanged. Pointers wrap modulo CMD_ENTRY_NUM.
- Max one push, one pop, one retry log and one grant per cycle. A table slot freed by a grant is reusable in the next cycle.

Optional Feature:
RETRY_AGING_EN: each valid table entry has a saturating age counter ($clog2(AGE_TH+1) bits), incremented every cycle it is not granted. Once age>=AGE_TH, effective QoS = QoS_CLASS-1 (promoted). Among promoted entries the oldest wins, with ties to the lowest index. Without the macro, selection is strict QoS priority with ties to the lowest index, there are no age counters, and starvation is possible.

Test Plan:
- Fill 8 entries with no pop, then send a 9th request with req_type=0 -> rdy_req_in=0, cnt stays 8, no retry issued.
- Buffer full, request src_id=3 qos=1 req_type=1 -> handshake, vld_rty_out=1 with rty_des_id=3 next cycle. Pop one -> vld_out_grant with grant_des_id=3, rsv=1, free=0.
- Full buffer, retries src 2 (qos 0) then src 5 (qos 3), then one pop -> grant to 5 first. Second pop -> grant to 2.
- After a grant to src 5, send req_credit=1 -> accepted, rsv 1->0, cnt+1. A further req_credit=1 -> rdy_req_in=0, err_credit=1.
- Retry table full (8 entries) with buffer full -> req_type=1 request gets rdy_req_in=0. Assert rst_n low mid-stream -> all outputs 0 asynchronously, cnt=rsv=0.
- With RETRY_AGING_EN and AGE_TH=15: qos-0 entry waits 15 cycles against a steady stream of qos-3 retries -> it is granted before newer qos-3 entries. Without the macro, the qos-3 entries win.
